// File: rtl/ram_arbiter_pkg.sv
// Shared encodings and request record for the I/D port arbiter in front of the data RAM.
// The round-robin pick is kept here so the policy lives in one place.
package ram_arbiter_pkg;

    localparam logic ENABLE    = 1'b1;
    localparam logic DISABLE   = 1'b0;
    localparam logic RAM_READ  = 1'b0;
    localparam logic RAM_WRITE = 1'b1;

    localparam int unsigned ARB_CNT_W = 4;
    typedef logic [ARB_CNT_W-1:0] arb_cnt_t;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_ACCESS = 1'b1
    } arb_state_t;

    typedef enum logic {
        ARB_PORT_I = 1'b0,
        ARB_PORT_D = 1'b1
    } arb_port_t;

    typedef struct packed {
        arb_port_t   port;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } arb_req_t;

    // On a tie the port that was not served last wins.
    function automatic arb_port_t arb_pick(input logic i_elig, input logic d_elig,
                                           input arb_port_t last);
        if (i_elig && d_elig) begin
            return (last == ARB_PORT_I) ? ARB_PORT_D : ARB_PORT_I;
        end
        return d_elig ? ARB_PORT_D : ARB_PORT_I;
    endfunction

endpackage

// File: rtl/ram_arbiter.sv
// Shares one data RAM between the instruction-fetch port (I, read-only) and the memory
// port (D, read/write); each access holds the RAM for WAIT_CYCLES cycles, then acks.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    output logic        i_stall,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_sel,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_stall,

    output logic        ram_ce,
    output logic        ram_op,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_sel,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    localparam arb_cnt_t CNT_INIT = arb_cnt_t'(WAIT_CYCLES - 1);

    arb_state_t  r_state;
    arb_cnt_t    r_count;
    arb_port_t   r_last;
    arb_req_t    r_req;
    logic        r_i_ack;
    logic        r_d_ack;
    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;

    logic        w_i_elig;
    logic        w_d_elig;
    logic        w_grant_valid;
    arb_port_t   w_grant_port;
    arb_req_t    w_grant_req;

    // A request still high in its own ack cycle is stale and must not re-grant.
    always_comb begin
        w_i_elig      = i_req & ~r_i_ack;
        w_d_elig      = d_req & ~r_d_ack;
        w_grant_valid = w_i_elig | w_d_elig;
        w_grant_port  = arb_pick(w_i_elig, w_d_elig, r_last);
        if (w_grant_port == ARB_PORT_D) begin
            w_grant_req = '{port: ARB_PORT_D, we: d_we, addr: d_addr, sel: d_sel,
                            wdata: d_wdata};
        end else begin
            w_grant_req = '{port: ARB_PORT_I, we: 1'b0, addr: i_addr, sel: 4'b1111,
                            wdata: 32'h0};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ARB_IDLE;
            r_count   <= '0;
            r_last    <= ARB_PORT_I;
            r_req     <= '0;
            r_i_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            r_i_ack <= 1'b0;
            r_d_ack <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_grant_valid) begin
                        r_state <= ARB_ACCESS;
                        r_count <= CNT_INIT;
                        r_last  <= w_grant_port;
                        r_req   <= w_grant_req;
                    end
                end
                ARB_ACCESS: begin
                    if (r_count != '0) begin
                        r_count <= r_count - 1'b1;
                    end else begin
                        r_state <= ARB_IDLE;
                        if (r_req.port == ARB_PORT_I) begin
                            r_i_ack   <= 1'b1;
                            r_i_rdata <= ram_rdata;
                        end else begin
                            r_d_ack <= 1'b1;
                            if (!r_req.we) begin
                                r_d_rdata <= ram_rdata;
                            end
                        end
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    // RAM strobes decode straight from state so reset drops ram_ce without a clock edge.
    always_comb begin
        ram_ce    = DISABLE;
        ram_op    = RAM_READ;
        ram_addr  = '0;
        ram_sel   = '0;
        ram_wdata = '0;
        if (r_state == ARB_ACCESS) begin
            ram_ce    = ENABLE;
            ram_op    = (r_req.we && r_count == '0) ? RAM_WRITE : RAM_READ;
            ram_addr  = r_req.addr;
            ram_sel   = r_req.sel;
            ram_wdata = r_req.wdata;
        end
    end

    assign i_ack   = r_i_ack;
    assign d_ack   = r_d_ack;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;
    assign i_stall = i_req & ~r_i_ack;
    assign d_stall = d_req & ~r_d_ack;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench: instance a runs WAIT_CYCLES=1, instance b runs WAIT_CYCLES=3, each
// against a small behavioural RAM with byte-lane writes and combinational reads.
module tb_ram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Instance a (WAIT_CYCLES=1)
    logic        rst_a;
    logic        i_req_a, i_ack_a, i_stall_a;
    logic [31:0] i_addr_a, i_rdata_a;
    logic        d_req_a, d_we_a, d_ack_a, d_stall_a;
    logic [31:0] d_addr_a, d_wdata_a, d_rdata_a;
    logic [3:0]  d_sel_a;
    logic        ram_ce_a, ram_op_a;
    logic [31:0] ram_addr_a, ram_wdata_a, ram_rdata_a;
    logic [3:0]  ram_sel_a;
    logic [31:0] mem_a [0:63];

    // Instance b (WAIT_CYCLES=3)
    logic        rst_b;
    logic        i_req_b, i_ack_b, i_stall_b;
    logic [31:0] i_addr_b, i_rdata_b;
    logic        d_req_b, d_we_b, d_ack_b, d_stall_b;
    logic [31:0] d_addr_b, d_wdata_b, d_rdata_b;
    logic [3:0]  d_sel_b;
    logic        ram_ce_b, ram_op_b;
    logic [31:0] ram_addr_b, ram_wdata_b, ram_rdata_b;
    logic [3:0]  ram_sel_b;
    logic [31:0] mem_b [0:63];

    ram_arbiter #(.WAIT_CYCLES(1)) u_dut_a (
        .clock(clk), .reset(rst_a),
        .i_req(i_req_a), .i_addr(i_addr_a), .i_ack(i_ack_a), .i_rdata(i_rdata_a),
        .i_stall(i_stall_a),
        .d_req(d_req_a), .d_we(d_we_a), .d_addr(d_addr_a), .d_sel(d_sel_a),
        .d_wdata(d_wdata_a), .d_ack(d_ack_a), .d_rdata(d_rdata_a), .d_stall(d_stall_a),
        .ram_ce(ram_ce_a), .ram_op(ram_op_a), .ram_addr(ram_addr_a), .ram_sel(ram_sel_a),
        .ram_wdata(ram_wdata_a), .ram_rdata(ram_rdata_a)
    );

    ram_arbiter #(.WAIT_CYCLES(3)) u_dut_b (
        .clock(clk), .reset(rst_b),
        .i_req(i_req_b), .i_addr(i_addr_b), .i_ack(i_ack_b), .i_rdata(i_rdata_b),
        .i_stall(i_stall_b),
        .d_req(d_req_b), .d_we(d_we_b), .d_addr(d_addr_b), .d_sel(d_sel_b),
        .d_wdata(d_wdata_b), .d_ack(d_ack_b), .d_rdata(d_rdata_b), .d_stall(d_stall_b),
        .ram_ce(ram_ce_b), .ram_op(ram_op_b), .ram_addr(ram_addr_b), .ram_sel(ram_sel_b),
        .ram_wdata(ram_wdata_b), .ram_rdata(ram_rdata_b)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    assign ram_rdata_a = mem_a[ram_addr_a[7:2]];
    assign ram_rdata_b = mem_b[ram_addr_b[7:2]];

    always @(posedge clk) begin
        if (ram_ce_a && ram_op_a) mem_a[ram_addr_a[7:2]] = merge(mem_a[ram_addr_a[7:2]],
                                                                 ram_wdata_a, ram_sel_a);
        if (ram_ce_b && ram_op_b) mem_b[ram_addr_b[7:2]] = merge(mem_b[ram_addr_b[7:2]],
                                                                 ram_wdata_b, ram_sel_b);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int w = 0; w < 64; w++) begin
            mem_a[w] = 32'h0;
            mem_b[w] = 32'h0;
        end
        mem_a[4]  = 32'hDEADBEEF;
        mem_a[8]  = 32'h11223344;
        mem_b[12] = 32'h55667788;
        mem_b[13] = 32'h01020304;

        rst_a = 1'b1; rst_b = 1'b1;
        i_req_a = 0; i_addr_a = 0; d_req_a = 0; d_we_a = 0; d_addr_a = 0; d_sel_a = 0;
        d_wdata_a = 0;
        i_req_b = 0; i_addr_b = 0; d_req_b = 0; d_we_b = 0; d_addr_b = 0; d_sel_b = 0;
        d_wdata_b = 0;

        // Reset values
        #3;
        chk("rst_ram_ce", ram_ce_a, 1'b0);
        chk("rst_ram_op", ram_op_a, 1'b0);
        chk("rst_i_ack", i_ack_a, 1'b0);
        chk("rst_d_ack", d_ack_a, 1'b0);
        chk("rst_i_rdata", i_rdata_a, 32'h0);
        chk("rst_d_rdata", d_rdata_a, 32'h0);
        tick();
        rst_a = 1'b0; rst_b = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("idle_ram_ce", ram_ce_a, 1'b0);
        end

        // Port I read, WAIT_CYCLES=1
        i_req_a = 1'b1; i_addr_a = 32'h10;
        tick();
        chk("i_rd_ce_c1", ram_ce_a, 1'b1);
        chk("i_rd_addr_c1", ram_addr_a, 32'h10);
        chk("i_rd_ack_c1", i_ack_a, 1'b0);
        chk("i_rd_stall_c1", i_stall_a, 1'b1);
        tick();
        chk("i_rd_ce_c2", ram_ce_a, 1'b0);
        chk("i_rd_ack_c2", i_ack_a, 1'b1);
        chk("i_rd_data", i_rdata_a, 32'hDEADBEEF);
        chk("i_rd_stall_c2", i_stall_a, 1'b0);
        i_req_a = 1'b0;
        tick();
        chk("i_rd_ack_c3", i_ack_a, 1'b0);
        chk("i_rd_ce_c3", ram_ce_a, 1'b0);

        // Port D partial write then read back
        d_req_a = 1'b1; d_we_a = 1'b1; d_addr_a = 32'h20; d_sel_a = 4'b0011;
        d_wdata_a = 32'hAABBCCDD;
        tick();
        chk("d_wr_ce", ram_ce_a, 1'b1);
        chk("d_wr_op", ram_op_a, 1'b1);
        chk("d_wr_sel", ram_sel_a, 4'b0011);
        tick();
        chk("d_wr_ack", d_ack_a, 1'b1);
        chk("d_wr_rdata_held", d_rdata_a, 32'h0);
        d_req_a = 1'b0;
        tick();
        d_req_a = 1'b1; d_we_a = 1'b0;
        tick();
        chk("d_rd_op", ram_op_a, 1'b0);
        tick();
        chk("d_rd_ack", d_ack_a, 1'b1);
        chk("d_rd_data", d_rdata_a, 32'h1122CCDD);
        d_req_a = 1'b0;
        tick();

        // Tie from reset: D first, then strict alternation with both held
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        i_req_a = 1'b1; i_addr_a = 32'h10;
        d_req_a = 1'b1; d_we_a = 1'b0; d_addr_a = 32'h20; d_sel_a = 4'b1111;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k % 2 == 1) begin
                chk("rr_ce", ram_ce_a, 1'b1);
                chk("rr_addr", ram_addr_a, (k % 4 == 1) ? 32'h20 : 32'h10);
            end else begin
                chk("rr_ce_gap", ram_ce_a, 1'b0);
                chk("rr_d_ack", d_ack_a, (k % 4 == 2) ? 1'b1 : 1'b0);
                chk("rr_i_ack", i_ack_a, (k % 4 == 0) ? 1'b1 : 1'b0);
            end
        end
        chk("rr_i_rdata", i_rdata_a, 32'hDEADBEEF);
        chk("rr_d_rdata", d_rdata_a, 32'h1122CCDD);
        i_req_a = 1'b0; d_req_a = 1'b0;
        tick();

        // WAIT_CYCLES=3 write: single write edge, late data change ignored
        d_req_b = 1'b1; d_we_b = 1'b1; d_addr_b = 32'h30; d_sel_b = 4'b1111;
        d_wdata_b = 32'hCAFEF00D;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) d_wdata_b = 32'h0BADBEEF;
            chk("w3_ce", ram_ce_b, (k <= 3) ? 1'b1 : 1'b0);
            chk("w3_op", ram_op_b, (k == 3) ? 1'b1 : 1'b0);
            chk("w3_ack", d_ack_b, (k == 4) ? 1'b1 : 1'b0);
            if (k == 3) chk("w3_wdata", ram_wdata_b, 32'hCAFEF00D);
        end
        d_req_b = 1'b0;
        tick();
        chk("w3_mem", mem_b[12], 32'hCAFEF00D);

        // Reset during the 2nd ACCESS cycle aborts the write
        d_req_b = 1'b1; d_we_b = 1'b1; d_addr_b = 32'h34; d_sel_b = 4'b1111;
        d_wdata_b = 32'hFFFFFFFF;
        tick();
        chk("ab_ce_c1", ram_ce_b, 1'b1);
        tick();
        chk("ab_ce_c2", ram_ce_b, 1'b1);
        rst_b = 1'b1;
        #1;
        chk("ab_ce_async", ram_ce_b, 1'b0);
        d_req_b = 1'b0;
        tick();
        chk("ab_ack_rst", d_ack_b, 1'b0);
        tick();
        rst_b = 1'b0;
        tick();
        chk("ab_ack_after", d_ack_b, 1'b0);
        chk("ab_ce_after", ram_ce_b, 1'b0);
        chk("ab_mem", mem_b[13], 32'h01020304);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
